// File: rtl/multiboot_pkg.sv
// Shared ICAP constants, state encoding and bit-swap helper for the
// Spartan-6 multiboot reader and writer.
package multiboot_pkg;

  // Configuration packet words as seen by the configuration logic
  // (before the byte-wise bit swap applied at the ICAP pins).
  localparam logic [15:0] ICAP_SYNC_WORD1 = 16'hAA99;
  localparam logic [15:0] ICAP_SYNC_WORD2 = 16'h5566;
  localparam logic [15:0] ICAP_NOOP       = 16'h2000;
  localparam logic [15:0] ICAP_DUMMY      = 16'hFFFF;

  // Type-1 write header to CMD, followed by the DESYNC command code.
  localparam logic [15:0] ICAP_WR_HDR_CMD = 16'h30A1;
  localparam logic [15:0] ICAP_CMD_DESYNC = 16'h000D;

  // Type-1 read headers, one word each.
  localparam logic [15:0] ICAP_RD_HDR_BOOTSTS  = 16'h2C01;
  localparam logic [15:0] ICAP_RD_HDR_GENERAL1 = 16'h2A61;
  localparam logic [15:0] ICAP_RD_HDR_GENERAL2 = 16'h2A81;

  // Index of the register currently being read back.
  localparam logic [1:0] REG_BOOTSTS  = 2'd0;
  localparam logic [1:0] REG_GENERAL1 = 2'd1;
  localparam logic [1:0] REG_GENERAL2 = 2'd2;

  // Reader sequence states, one ICAP word slot per state.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SYNC1 = 4'd1,
    ST_SYNC2 = 4'd2,
    ST_NOP0  = 4'd3,
    ST_HDR   = 4'd4,
    ST_NOPA  = 4'd5,
    ST_NOPB  = 4'd6,
    ST_TO_RD = 4'd7,
    ST_READ  = 4'd8,
    ST_TO_WR = 4'd9,
    ST_CMD   = 4'd10,
    ST_DSY   = 4'd11,
    ST_NOPC  = 4'd12,
    ST_NOPD  = 4'd13,
    ST_FIN   = 4'd14
  } msr_state_e;

  // ICAP pins carry each byte bit-reversed relative to the packet word.
  // The swap is its own inverse, so it serves both directions.
  function automatic logic [15:0] icap_bitswap16(input logic [15:0] din);
    logic [15:0] dout;
    for (int i = 0; i < 8; i++) begin
      dout[i]     = din[7 - i];
      dout[8 + i] = din[15 - i];
    end
    return dout;
  endfunction

  // Read header for a register index; unknown indices fall back to NOOP.
  function automatic logic [15:0] read_header(input logic [1:0] idx);
    logic [15:0] hdr;
    case (idx)
      REG_BOOTSTS:  hdr = ICAP_RD_HDR_BOOTSTS;
      REG_GENERAL1: hdr = ICAP_RD_HDR_GENERAL1;
      REG_GENERAL2: hdr = ICAP_RD_HDR_GENERAL2;
      default:      hdr = ICAP_NOOP;
    endcase
    return hdr;
  endfunction

endpackage

// File: rtl/multiboot_status_reader.sv
// ICAP readback of BOOTSTS, GENERAL1 and GENERAL2 on Spartan-6.
// Syncs the configuration port, issues one read per register, desyncs,
// and reports the boot status plus the warm-boot SPI address/opcode.
//
// Handshake: start is a level request sampled only in IDLE (and is
// ignored while busy). busy rises the cycle after start is taken and
// stays high through FIN; done pulses for exactly one cycle in FIN.
// error and status_valid are valid from done onward and hold until the
// next accepted start clears them.
module multiboot_status_reader
  import multiboot_pkg::*;
#(
  parameter bit          AUTO_START = 1'b1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        MBT_RESET,
  input  logic        start,
  output logic        icap_ce,
  output logic        icap_wr,
  output logic [15:0] icap_i,
  input  logic [15:0] icap_o,
  input  logic        icap_busy,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        status_valid,
  output logic [15:0] bootsts,
  output logic [23:0] next_addr,
  output logic [7:0]  next_opcode,
  output msr_state_e  dbg_state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  msr_state_e  state;
  msr_state_e  state_nxt;
  logic [1:0]  reg_idx;
  logic [7:0]  rd_cnt;
  logic        pending;
  logic [15:0] general1;
  logic [15:0] general2;

  logic        go;
  logic        rd_ok;
  logic        rd_timeout;
  logic        last_reg;

  logic        ce_c;
  logic        wr_c;
  logic [15:0] din_c;

  assign go         = start | pending;
  assign rd_ok      = (rd_cnt >= 8'd2) && !icap_busy;
  assign rd_timeout = !rd_ok && (rd_cnt >= TIMEOUT_CNT);
  assign last_reg   = error || (reg_idx == REG_GENERAL2);

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FIN);
  assign next_addr   = {general2[7:0], general1};
  assign next_opcode = general2[15:8];
  assign dbg_state   = state;

  // State register.
  always_ff @(posedge CLK) begin
    if (MBT_RESET) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state: one word per state, READ waits for data or timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (go) state_nxt = ST_SYNC1;
      ST_SYNC1: state_nxt = ST_SYNC2;
      ST_SYNC2: state_nxt = ST_NOP0;
      ST_NOP0:  state_nxt = ST_HDR;
      ST_HDR:   state_nxt = ST_NOPA;
      ST_NOPA:  state_nxt = ST_NOPB;
      ST_NOPB:  state_nxt = ST_TO_RD;
      ST_TO_RD: state_nxt = ST_READ;
      ST_READ:  if (rd_ok || rd_timeout) state_nxt = ST_TO_WR;
      ST_TO_WR: state_nxt = last_reg ? ST_CMD : ST_HDR;
      ST_CMD:   state_nxt = ST_DSY;
      ST_DSY:   state_nxt = ST_NOPC;
      ST_NOPC:  state_nxt = ST_NOPD;
      ST_NOPD:  state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: ICAP control and packet word for the current state.
  always_comb begin
    ce_c  = 1'b1;
    wr_c  = 1'b1;
    din_c = ICAP_DUMMY;
    unique case (state)
      ST_SYNC1: begin ce_c = 1'b0; wr_c = 1'b0; din_c = ICAP_SYNC_WORD1; end
      ST_SYNC2: begin ce_c = 1'b0; wr_c = 1'b0; din_c = ICAP_SYNC_WORD2; end
      ST_NOP0,
      ST_NOPA,
      ST_NOPB,
      ST_NOPC,
      ST_NOPD:  begin ce_c = 1'b0; wr_c = 1'b0; din_c = ICAP_NOOP; end
      ST_HDR:   begin ce_c = 1'b0; wr_c = 1'b0; din_c = read_header(reg_idx); end
      ST_TO_RD: begin ce_c = 1'b1; wr_c = 1'b1; end
      ST_READ:  begin ce_c = 1'b0; wr_c = 1'b1; end
      ST_TO_WR: begin ce_c = 1'b1; wr_c = 1'b0; end
      ST_CMD:   begin ce_c = 1'b0; wr_c = 1'b0; din_c = ICAP_WR_HDR_CMD; end
      ST_DSY:   begin ce_c = 1'b0; wr_c = 1'b0; din_c = ICAP_CMD_DESYNC; end
      default:  begin ce_c = 1'b1; wr_c = 1'b1; din_c = ICAP_DUMMY; end
    endcase
  end

  // Register the ICAP request one stage, swapping bits on the way out.
  always_ff @(posedge CLK) begin
    if (MBT_RESET) begin
      icap_ce <= 1'b1;
      icap_wr <= 1'b1;
      icap_i  <= ICAP_DUMMY;
    end else begin
      icap_ce <= ce_c;
      icap_wr <= wr_c;
      icap_i  <= icap_bitswap16(din_c);
    end
  end

  // Sequence bookkeeping: pending auto-start, read counter, register
  // index, captured data and the error/valid flags.
  always_ff @(posedge CLK) begin
    if (MBT_RESET) begin
      pending      <= AUTO_START;
      rd_cnt       <= 8'd0;
      reg_idx      <= REG_BOOTSTS;
      error        <= 1'b0;
      status_valid <= 1'b0;
      bootsts      <= 16'h0000;
      general1     <= 16'h0000;
      general2     <= 16'h0000;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            pending      <= 1'b0;
            reg_idx      <= REG_BOOTSTS;
            error        <= 1'b0;
            status_valid <= 1'b0;
          end
        end
        ST_TO_RD: rd_cnt <= 8'd0;
        ST_READ: begin
          if (rd_cnt != 8'hFF) rd_cnt <= rd_cnt + 8'd1;
          if (rd_ok) begin
            case (reg_idx)
              REG_BOOTSTS:  bootsts  <= icap_bitswap16(icap_o);
              REG_GENERAL1: general1 <= icap_bitswap16(icap_o);
              REG_GENERAL2: general2 <= icap_bitswap16(icap_o);
              default:      ;
            endcase
          end else if (rd_timeout) begin
            error <= 1'b1;
          end
        end
        ST_TO_WR: if (!last_reg) reg_idx <= reg_idx + 2'd1;
        // Raise status_valid on entry to FIN so it is valid with done.
        ST_NOPD:  status_valid <= !error;
        default:  ;
      endcase
    end
  end

endmodule
